seg_scan_decoder: RTL

//  Inverse of the display encoder. Watches a multiplexed active-low 7-segment bus
//  (segment lines plus one-hot digit enables) and recovers the BCD value shown on each digit.
//  A pattern is accepted only after it has been stable for STABLE_CYCLES qualified samples.

---
 rtl/seg_scan_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit BCD values from a multiplexed active-low 7-segment bus and emits change events.
// Optional SEG_DP_EN widens seg_in to 8 bits and adds out_dp carrying the decimal point state.
module seg_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
`ifdef SEG_DP_EN
  localparam int SW = 8
`else
  localparam int SW = 7
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic [SW-1:0]         seg_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_digit,
  output logic [3:0]            out_value,
  output logic                  out_err,
  output logic                  overflow,
`ifdef SEG_DP_EN
  output logic                  out_dp,
`endif
  output logic [4*DIGITS-1:0]   digit_values
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            state_p0, state_n;
  logic [DIGITS-1:0] cap_en_p0, cap_en_n;
  logic [SW-1:0]     cap_seg_p0, cap_seg_n;
  logic [CW-1:0]     cnt_p0, cnt_n;
  logic              commit;
  logic              qual;
  logic [4:0]        dec;
  logic [3:0]        dec_val;
  logic              dec_err;
  logic [3:0]        old_val;
  logic [DW-1:0]     dig_idx;
  logic              evt;

  // Returns {err, value}; unknown patterns decode to value F with err set.
  function automatic logic [4:0] decode7(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h18:   r = 5'h09;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] onehot_idx(input logic [DIGITS-1:0] v);
    logic [DW-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (v[i]) idx = DW'(i);
    return idx;
  endfunction

  assign qual    = ($countones(dig_en) == 1);
  assign dec     = decode7(seg_in[6:0]);
  assign dec_val = dec[3:0];
  assign dec_err = dec[4];
  assign dig_idx = onehot_idx(dig_en);

  always_comb begin
    old_val = 4'hF;
    for (int i = 0; i < DIGITS; i++)
      if (dig_en[i]) old_val = digit_values[4*i +: 4];
  end

  // Stability tracker: count identical qualified samples, commit once per stable run.
  always_comb begin
    state_n   = state_p0;
    cap_en_n  = cap_en_p0;
    cap_seg_n = cap_seg_p0;
    cnt_n     = cnt_p0;
    commit    = 1'b0;
    if (sample_en) begin
      if (!qual) begin
        cnt_n   = '0;
        state_n = SEARCH;
      end else if (dig_en == cap_en_p0 && seg_in == cap_seg_p0) begin
        if (state_p0 == SEARCH) begin
          cnt_n = cnt_p0 + CW'(1);
          if (cnt_n == CW'(STABLE_CYCLES)) begin
            commit  = 1'b1;
            state_n = LOCKED;
          end
        end
      end else begin
        cap_en_n  = dig_en;
        cap_seg_n = seg_in;
        cnt_n     = CW'(1);
        if (STABLE_CYCLES == 1) begin
          commit  = 1'b1;
          state_n = LOCKED;
        end else begin
          state_n = SEARCH;
        end
      end
    end
  end

`ifdef SEG_DP_EN
  logic [DIGITS-1:0] dp_vals;
  logic              dp_lit;
  logic              old_dp;

  assign dp_lit = ~seg_in[7];

  always_comb begin
    old_dp = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (dig_en[i]) old_dp = dp_vals[i];
  end

  assign evt = commit && (dec_err || (dec_val != old_val) || (dp_lit != old_dp));
`else
  assign evt = commit && (dec_err || (dec_val != old_val));
`endif

  // Commit/event stage: update stored digits and the output event register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0     <= SEARCH;
      cap_en_p0    <= '0;
      cap_seg_p0   <= '0;
      cnt_p0       <= '0;
      out_valid    <= 1'b0;
      out_digit    <= '0;
      out_value    <= 4'h0;
      out_err      <= 1'b0;
      overflow     <= 1'b0;
      digit_values <= {DIGITS{4'hF}};
`ifdef SEG_DP_EN
      dp_vals      <= '0;
      out_dp       <= 1'b0;
`endif
    end else begin
      state_p0   <= state_n;
      cap_en_p0  <= cap_en_n;
      cap_seg_p0 <= cap_seg_n;
      cnt_p0     <= cnt_n;
      if (commit) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_en[i]) begin
            digit_values[4*i +: 4] <= dec_val;
`ifdef SEG_DP_EN
            dp_vals[i]             <= dp_lit;
`endif
          end
        end
      end
      if (evt) begin
        if (!out_valid || out_ready) begin
          out_valid <= 1'b1;
          out_digit <= dig_idx;
          out_value <= dec_val;
          out_err   <= dec_err;
`ifdef SEG_DP_EN
          out_dp    <= dp_lit;
`endif
        end else begin
          overflow <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
